u3v_pixel_packer: RTL and testbench

- Sits directly downstream of the MIPI D-PHY to CMOS bridge, in the pixel clock domain.
- Consumes the 10-bit parallel pixel bus and the fv/lv strobes, and packs pixels two per 32-bit word as Mono10 unpacked (16 bits per pixel, zero-extended).
- Brackets each frame with a header word and a trailer word, and writes the stream into the U3V streaming FIFO.
- Provides frame and line counters plus sticky error reporting.

---
 rtl/u3v_pixel_packer_if.sv | 25 ++
 rtl/u3v_pixel_packer.sv | 206 ++++++++++++++++++++
 tb/tb_u3v_pixel_packer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/u3v_pixel_packer_if.sv
// FIFO write-side bundle between the pixel packer and the U3V streaming FIFO.
// The packer drives word/markers as master; the FIFO returns its full flag.
interface u3v_pixel_packer_if;
   logic        fifo_wr_o;
   logic [31:0] fifo_data_o;
   logic        fifo_sof_o;
   logic        fifo_eof_o;
   logic        fifo_full_i;

   modport master (
      output fifo_wr_o,
      output fifo_data_o,
      output fifo_sof_o,
      output fifo_eof_o,
      input  fifo_full_i
   );

   modport slave (
      input  fifo_wr_o,
      input  fifo_data_o,
      input  fifo_sof_o,
      input  fifo_eof_o,
      output fifo_full_i
   );
endinterface

// File: rtl/u3v_pixel_packer.sv
// Packs Mono10 pixels two per 32-bit word, framed by header/trailer words.
// Latency: input sample edge k -> FIFO write visible after edge k+1; full drops words, never stalls.
module u3v_pixel_packer #(
   parameter int PIX_W = 10,
   parameter int CNT_W = 16
) (
   input  logic             clk_pixel_i,
   input  logic             reset_pixel_n_i,
   input  logic             fv_i,
   input  logic             lv_i,
   input  logic [PIX_W-1:0] pd_i,
   input  logic             enable_i,
   input  logic             clr_err_i,
   u3v_pixel_packer_if.master fifo_if,
   output logic [CNT_W-1:0] frame_cnt_o,
   output logic [CNT_W-1:0] line_cnt_o,
   output logic             overflow_o,
   output logic             frame_drop_o
);

   typedef enum logic [2:0] {
      S_WAIT_LOW = 3'd0,
      S_IDLE     = 3'd1,
      S_ACTIVE   = 3'd2,
      S_TRAILER  = 3'd3,
      S_SKIP     = 3'd4
   } state_e;

   state_e state_q, state_d;

   // Input stage and edge-detect history
   logic             fv_q, lv_q, fv_qq, lv_qq;
   logic [PIX_W-1:0] pd_q;
   logic             primed_q;

   logic [15:0]      low_q, low_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
   logic             odd_err_q, odd_err_d;
   logic             ovf_err_q, ovf_err_d;
   logic             overflow_q, overflow_d;
   logic             frame_drop_q, frame_drop_d;

   logic             wr_q, wr_d;
   logic [31:0]      data_q, data_d;
   logic             sof_q, sof_d;
   logic             eof_q, eof_d;

   logic             fv_rise, fv_fall, lv_fall, pix_vld;
   logic [15:0]      pix16;

   logic             wr_req, sof_req, eof_req, drop_set, ovf_keep;
   logic [31:0]      word;
   logic             dropped;

   assign fv_rise = fv_q & ~fv_qq;
   assign fv_fall = ~fv_q & fv_qq;
   assign lv_fall = ~lv_q & lv_qq;
   assign pix_vld = fv_q & lv_q;
   assign pix16   = 16'(pd_q);

   always_ff @(posedge clk_pixel_i or negedge reset_pixel_n_i) begin
      if (!reset_pixel_n_i) begin
         fv_q     <= 1'b0;
         lv_q     <= 1'b0;
         pd_q     <= '0;
         fv_qq    <= 1'b0;
         lv_qq    <= 1'b0;
         primed_q <= 1'b0;
      end else begin
         fv_q     <= fv_i;
         lv_q     <= lv_i;
         pd_q     <= pd_i;
         fv_qq    <= fv_q;
         lv_qq    <= lv_q;
         primed_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_pixel_i or negedge reset_pixel_n_i) begin
      if (!reset_pixel_n_i) begin
         state_q <= S_WAIT_LOW;
      end else begin
         state_q <= state_d;
      end
   end

   // WAIT_LOW ignores the reset value of fv_q so a frame already in flight cannot fake a rise
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_WAIT_LOW: if (primed_q && !fv_q) state_d = S_IDLE;
         S_IDLE:     if (fv_rise) state_d = enable_i ? S_ACTIVE : S_SKIP;
         S_ACTIVE:   if (fv_fall) state_d = S_TRAILER;
         S_TRAILER:  state_d = fv_rise ? S_SKIP : S_IDLE;
         S_SKIP:     if (fv_fall) state_d = S_IDLE;
         default:    state_d = S_WAIT_LOW;
      endcase
   end

   always_comb begin
      wr_req      = 1'b0;
      sof_req     = 1'b0;
      eof_req     = 1'b0;
      drop_set    = 1'b0;
      ovf_keep    = ovf_err_q;
      word        = 32'h0;
      low_d       = low_q;
      pend_d      = pend_q;
      frame_cnt_d = frame_cnt_q;
      line_cnt_d  = line_cnt_q;
      odd_err_d   = odd_err_q;
      case (state_q)
         S_IDLE: begin
            if (fv_rise && enable_i) begin
               wr_req      = 1'b1;
               sof_req     = 1'b1;
               word        = {8'hA5, 8'h00, 16'(frame_cnt_q)};
               frame_cnt_d = frame_cnt_q + 1'b1;
               line_cnt_d  = '0;
               odd_err_d   = 1'b0;
               ovf_keep    = 1'b0;
               low_d       = pix16;
               pend_d      = pix_vld;
            end
         end
         S_ACTIVE: begin
            if (pix_vld) begin
               if (pend_q) begin
                  wr_req = 1'b1;
                  word   = {pix16, low_q};
                  pend_d = 1'b0;
               end else begin
                  low_d  = pix16;
                  pend_d = 1'b1;
               end
            end
            if (lv_fall) line_cnt_d = line_cnt_q + 1'b1;
            // A sample cannot carry a pixel and a fall at once, so the flush never collides
            if ((lv_fall || fv_fall) && pend_q) begin
               wr_req    = 1'b1;
               word      = {16'h0000, low_q};
               pend_d    = 1'b0;
               odd_err_d = 1'b1;
            end
         end
         S_TRAILER: begin
            wr_req   = 1'b1;
            eof_req  = 1'b1;
            word     = {8'h5A, 6'b0, odd_err_q, ovf_err_q, 16'(line_cnt_q)};
            drop_set = fv_rise;
         end
         default: ;
      endcase
   end

   assign dropped      = wr_req & fifo_if.fifo_full_i;
   assign ovf_err_d    = ovf_keep | dropped;
   assign overflow_d   = (overflow_q & ~clr_err_i) | dropped;
   assign frame_drop_d = (frame_drop_q & ~clr_err_i) | drop_set;
   assign wr_d         = wr_req & ~fifo_if.fifo_full_i;
   assign sof_d        = sof_req & ~fifo_if.fifo_full_i;
   assign eof_d        = eof_req & ~fifo_if.fifo_full_i;
   assign data_d       = wr_req ? word : data_q;

   always_ff @(posedge clk_pixel_i or negedge reset_pixel_n_i) begin
      if (!reset_pixel_n_i) begin
         low_q        <= '0;
         pend_q       <= 1'b0;
         frame_cnt_q  <= '0;
         line_cnt_q   <= '0;
         odd_err_q    <= 1'b0;
         ovf_err_q    <= 1'b0;
         overflow_q   <= 1'b0;
         frame_drop_q <= 1'b0;
         wr_q         <= 1'b0;
         data_q       <= '0;
         sof_q        <= 1'b0;
         eof_q        <= 1'b0;
      end else begin
         low_q        <= low_d;
         pend_q       <= pend_d;
         frame_cnt_q  <= frame_cnt_d;
         line_cnt_q   <= line_cnt_d;
         odd_err_q    <= odd_err_d;
         ovf_err_q    <= ovf_err_d;
         overflow_q   <= overflow_d;
         frame_drop_q <= frame_drop_d;
         wr_q         <= wr_d;
         data_q       <= data_d;
         sof_q        <= sof_d;
         eof_q        <= eof_d;
      end
   end

   assign fifo_if.fifo_wr_o   = wr_q;
   assign fifo_if.fifo_data_o = data_q;
   assign fifo_if.fifo_sof_o  = sof_q;
   assign fifo_if.fifo_eof_o  = eof_q;
   assign frame_cnt_o         = frame_cnt_q;
   assign line_cnt_o          = line_cnt_q;
   assign overflow_o          = overflow_q;
   assign frame_drop_o        = frame_drop_q;

endmodule

// File: tb/tb_u3v_pixel_packer.sv
// Directed frames against the pixel packer; writes are checked by a queue-driven monitor.
module tb_u3v_pixel_packer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, fv, lv, en, clr;
   logic [9:0]  pd;
   logic [15:0] fcnt, lcnt;
   logic        ovf, fdrop;

   u3v_pixel_packer_if fif();

   u3v_pixel_packer #(.PIX_W(10), .CNT_W(16)) dut (
      .clk_pixel_i     (clk),
      .reset_pixel_n_i (rst_n),
      .fv_i            (fv),
      .lv_i            (lv),
      .pd_i            (pd),
      .enable_i        (en),
      .clr_err_i       (clr),
      .fifo_if         (fif),
      .frame_cnt_o     (fcnt),
      .line_cnt_o      (lcnt),
      .overflow_o      (ovf),
      .frame_drop_o    (fdrop)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   int          full_cd = 0;
   logic [33:0] exp_q[$];
   logic [33:0] m_exp, m_got;
   logic [9:0]  pix [8];

   task automatic push(input logic s, input logic e, input logic [31:0] d);
      exp_q.push_back({s, e, d});
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every write pops one expected {sof, eof, data}
   always @(negedge clk) begin
      if (fif.fifo_wr_o === 1'b1) begin
         n_tests++;
         m_got = {fif.fifo_sof_o, fif.fifo_eof_o, fif.fifo_data_o};
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got sof=%b eof=%b data=%h, required no write",
                     m_got[33], m_got[32], m_got[31:0]);
         end else begin
            m_exp = exp_q.pop_front();
            if (m_got !== m_exp) begin
               n_fail++;
               $display("FAIL fifo_word: got sof=%b eof=%b data=%h, required sof=%b eof=%b data=%h",
                        m_got[33], m_got[32], m_got[31:0], m_exp[33], m_exp[32], m_exp[31:0]);
            end
         end
      end
   end

   task automatic step(input logic f, input logic l, input logic [9:0] p);
      fv = f;
      lv = l;
      pd = p;
      fif.fifo_full_i = (full_cd > 0);
      if (full_cd > 0) full_cd--;
      @(negedge clk);
   endtask

   // One frame: fv lead-in, nl lines of ppl pixels from pix[], then lowc cycles of fv low.
   // full_pix names a pixel whose completed word sees fifo_full over the next two cycles.
   task automatic frame(input int nl, input int ppl, input int lowc, input int full_pix);
      step(1'b1, 1'b0, 10'h0);
      for (int l = 0; l < nl; l++) begin
         for (int i = 0; i < ppl; i++) begin
            step(1'b1, 1'b1, pix[l*ppl+i]);
            if (l*ppl+i == full_pix) full_cd = 2;
         end
         step(1'b1, 1'b0, 10'h0);
         step(1'b1, 1'b0, 10'h0);
      end
      for (int i = 0; i < lowc; i++) step(1'b0, 1'b0, 10'h0);
   endtask

   task automatic set_nominal();
      pix[0] = 10'h001; pix[1] = 10'h002; pix[2] = 10'h003; pix[3] = 10'h004;
      pix[4] = 10'h3FF; pix[5] = 10'h3FE; pix[6] = 10'h3FD; pix[7] = 10'h3FC;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; fv = 1'b0; lv = 1'b0; pd = '0; en = 1'b1; clr = 1'b0;
      fif.fifo_full_i = 1'b0;
      for (int i = 0; i < 8; i++) pix[i] = '0;
      repeat (3) @(negedge clk);
      chk("rst_wr", {31'b0, fif.fifo_wr_o}, 32'd0);
      chk("rst_data", fif.fifo_data_o, 32'd0);
      chk("rst_frame_cnt", {16'b0, fcnt}, 32'd0);
      chk("rst_line_cnt", {16'b0, lcnt}, 32'd0);
      chk("rst_flags", {30'b0, ovf, fdrop}, 32'd0);
      rst_n = 1'b1;
      repeat (3) step(1'b0, 1'b0, 10'h0);

      // Nominal frame
      set_nominal();
      push(1, 0, 32'hA5000000); push(0, 0, 32'h00020001); push(0, 0, 32'h00040003);
      push(0, 0, 32'h03FE03FF); push(0, 0, 32'h03FC03FD); push(0, 1, 32'h5A000002);
      frame(2, 4, 6, -1);
      chk("nom_frame_cnt", {16'b0, fcnt}, 32'd1);
      chk("nom_line_cnt", {16'b0, lcnt}, 32'd2);
      chk("nom_drained", exp_q.size(), 32'd0);

      // Odd pixel count per line
      pix[0] = 10'h010; pix[1] = 10'h020; pix[2] = 10'h030;
      push(1, 0, 32'hA5000001); push(0, 0, 32'h00200010); push(0, 0, 32'h00000030);
      push(0, 1, 32'h5A020001);
      frame(1, 3, 6, -1);
      chk("odd_frame_cnt", {16'b0, fcnt}, 32'd2);
      chk("odd_line_cnt", {16'b0, lcnt}, 32'd1);
      chk("odd_drained", exp_q.size(), 32'd0);

      // FIFO full while the second data word is presented
      set_nominal();
      push(1, 0, 32'hA5000002); push(0, 0, 32'h00020001);
      push(0, 0, 32'h03FE03FF); push(0, 0, 32'h03FC03FD); push(0, 1, 32'h5A010002);
      frame(2, 4, 6, 3);
      chk("full_overflow_set", {31'b0, ovf}, 32'd1);
      chk("full_drained", exp_q.size(), 32'd0);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("full_overflow_clr", {31'b0, ovf}, 32'd0);

      // Disabled frame is skipped silently
      en = 1'b0;
      pix[0] = 10'h111; pix[1] = 10'h222;
      frame(1, 2, 6, -1);
      chk("dis_frame_cnt", {16'b0, fcnt}, 32'd3);
      chk("dis_no_drop", {31'b0, fdrop}, 32'd0);
      en = 1'b1;
      pix[0] = 10'h155; pix[1] = 10'h2AA;
      push(1, 0, 32'hA5000003); push(0, 0, 32'h02AA0155); push(0, 1, 32'h5A000001);
      frame(1, 2, 6, -1);
      chk("en_frame_cnt", {16'b0, fcnt}, 32'd4);
      chk("en_drained", exp_q.size(), 32'd0);

      // Reset in the middle of a line, released with fv still high
      push(1, 0, 32'hA5000004);
      repeat (3) step(1'b1, 1'b0, 10'h0);
      step(1'b1, 1'b1, 10'h011);
      rst_n = 1'b0;
      step(1'b1, 1'b1, 10'h012);
      step(1'b1, 1'b1, 10'h013);
      chk("mid_rst_frame_cnt", {16'b0, fcnt}, 32'd0);
      chk("mid_rst_wr", {31'b0, fif.fifo_wr_o}, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 10'(10'h020 + i));
      step(1'b1, 1'b0, 10'h0);
      step(1'b1, 1'b1, 10'h031);
      step(1'b1, 1'b1, 10'h032);
      repeat (2) step(1'b1, 1'b0, 10'h0);
      repeat (3) step(1'b0, 1'b0, 10'h0);
      chk("mid_rst_quiet", exp_q.size(), 32'd0);
      pix[0] = 10'h0AB; pix[1] = 10'h0CD;
      push(1, 0, 32'hA5000000); push(0, 0, 32'h00CD00AB); push(0, 1, 32'h5A000001);
      frame(1, 2, 6, -1);
      chk("post_rst_frame_cnt", {16'b0, fcnt}, 32'd1);

      // fv low for one sample: next frame rises during the trailer cycle
      pix[0] = 10'h001; pix[1] = 10'h002;
      push(1, 0, 32'hA5000001); push(0, 0, 32'h00020001); push(0, 1, 32'h5A000001);
      frame(1, 2, 1, -1);
      pix[0] = 10'h007; pix[1] = 10'h008;
      frame(1, 2, 6, -1);
      chk("coll_frame_cnt", {16'b0, fcnt}, 32'd2);
      chk("coll_line_cnt", {16'b0, lcnt}, 32'd1);
      chk("coll_drop_set", {31'b0, fdrop}, 32'd1);
      chk("coll_drained", exp_q.size(), 32'd0);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("coll_drop_clr", {31'b0, fdrop}, 32'd0);

      repeat (4) @(negedge clk);
      chk("final_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
